// File: rtl/cache_mem_arbiter.sv
// Two-requester arbiter (I-cache, D-cache) sharing one line-wide memory port.
// Optional macro ARB_RR_EN selects round-robin tie-break; default is fixed D priority.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  localparam logic RR_I = 1'b0;
  localparam logic RR_D = 1'b1;

  state_e state_q, state_d;
  logic   rr_last_q, rr_last_d;
  logic   req_i_s, req_d_s;
  logic   grant_i_s, grant_d_s;

  assign req_i_s = i_read | i_write;
  assign req_d_s = d_read | d_write;

  // Next-state and round-robin bookkeeping
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (req_i_s && req_d_s) begin
`ifdef ARB_RR_EN
          state_d = (rr_last_q == RR_D) ? GRANT_I : GRANT_D;
`else
          state_d = GRANT_D;
`endif
        end else if (req_d_s) begin
          state_d = GRANT_D;
        end else if (req_i_s) begin
          state_d = GRANT_I;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_I: begin
        if (!req_i_s) begin
          state_d = IDLE;
        end else if (pmem_resp) begin
          state_d   = IDLE;
          rr_last_d = RR_I;
        end else begin
          state_d = GRANT_I;
        end
      end
      GRANT_D: begin
        if (!req_d_s) begin
          state_d = IDLE;
        end else if (pmem_resp) begin
          state_d   = IDLE;
          rr_last_d = RR_D;
        end else begin
          state_d = GRANT_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and last-served registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= RR_I;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Reset drops the grant in the same cycle so an abandoned transfer never strobes or responds
  assign grant_i_s = rst_n && (state_q == GRANT_I);
  assign grant_d_s = rst_n && (state_q == GRANT_D);

  // Output steering; write wins when a requester raises both strobes
  always_comb begin
    pmem_address = grant_i_s ? i_address : d_address;
    pmem_wdata   = grant_i_s ? i_wdata   : d_wdata;
    pmem_write   = (grant_i_s & i_write) | (grant_d_s & d_write);
    pmem_read    = (grant_i_s & i_read & ~i_write) | (grant_d_s & d_read & ~d_write);
    i_resp       = grant_i_s & req_i_s & pmem_resp;
    d_resp       = grant_d_s & req_d_s & pmem_resp;
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
